cu_fsm: RTL and testbench

Multicycle control state machine for the RV32I core. It sequences fetch, execute, load writeback and interrupt entry, and drives every write enable and read enable in the datapath. It also drives the writeback selector (`RF_SEL`) of the register-file input mux, so the value written to the register file always matches the state that commits it. Outputs are combinational from state and inputs; the only storage is the state register.

---
 rtl/cu_fsm.sv | 136 +++++++++++++
 tb/tb_cu_fsm.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/cu_fsm.sv
// Multicycle control FSM for the RV32I core: sequences fetch, execute, load
// writeback and trap entry, and drives every datapath enable and the writeback select.
module cu_fsm #(
   parameter logic INTR_EN = 1'b1
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       INTR,
   input  logic       MIE,
   input  logic [6:0] OPCODE,
   input  logic [2:0] FUNC3,
   input  logic       MEM_READY,
   output logic       RST,
   output logic       PC_WE,
   output logic       RF_WE,
   output logic [1:0] RF_SEL,
   output logic       MEM_RDEN1,
   output logic       MEM_RDEN2,
   output logic       MEM_WE2,
   output logic       CSR_WE,
   output logic       INT_TAKEN,
   output logic       MRET_EXEC
);

   typedef enum logic [2:0] {
      ST_INIT,
      ST_FETCH,
      ST_EXEC,
      ST_WB,
      ST_INTR
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_ALU    = 7'b0110011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;

   state_t r_state;
   state_t w_nextState;
   logic   w_irq;
   state_t w_boundaryState;

   assign w_irq = INTR_EN & INTR & MIE;

   // Interrupts are only taken at an instruction boundary.
   assign w_boundaryState = w_irq ? ST_INTR : ST_FETCH;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) r_state <= ST_INIT;
      else        r_state <= w_nextState;
   end

   always_comb begin
      w_nextState = r_state;
      RST         = 1'b0;
      PC_WE       = 1'b0;
      RF_WE       = 1'b0;
      RF_SEL      = 2'd3;
      MEM_RDEN1   = 1'b0;
      MEM_RDEN2   = 1'b0;
      MEM_WE2     = 1'b0;
      CSR_WE      = 1'b0;
      INT_TAKEN   = 1'b0;
      MRET_EXEC   = 1'b0;

      case (r_state)
         ST_INIT: begin
            RST         = 1'b1;
            w_nextState = ST_FETCH;
         end

         ST_FETCH: begin
            MEM_RDEN1   = 1'b1;
            w_nextState = ST_EXEC;
         end

         ST_EXEC: begin
            w_nextState = w_boundaryState;
            PC_WE       = 1'b1;
            case (OPCODE)
               OP_LOAD: begin
                  PC_WE       = 1'b0;
                  MEM_RDEN2   = 1'b1;
                  w_nextState = ST_WB;
               end
               OP_STORE: MEM_WE2 = 1'b1;
               OP_BRANCH: ;
               OP_ALU, OP_ALUI, OP_LUI, OP_AUIPC: begin
                  RF_WE  = 1'b1;
                  RF_SEL = 2'd3;
               end
               OP_JAL, OP_JALR: begin
                  RF_WE  = 1'b1;
                  RF_SEL = 2'd0;
               end
               OP_SYSTEM: begin
                  if (FUNC3 == 3'b000) begin
                     MRET_EXEC = 1'b1;
                  end else if (FUNC3 == 3'b001 || FUNC3 == 3'b010 || FUNC3 == 3'b011) begin
                     RF_WE  = 1'b1;
                     RF_SEL = 2'd1;
                     CSR_WE = 1'b1;
                  end
               end
               default: ;
            endcase
         end

         // Load data is selected for the whole state so the mux is settled before the commit.
         ST_WB: begin
            RF_SEL    = 2'd2;
            MEM_RDEN2 = 1'b1;
            if (MEM_READY) begin
               RF_WE       = 1'b1;
               PC_WE       = 1'b1;
               w_nextState = w_boundaryState;
            end
         end

         ST_INTR: begin
            INT_TAKEN   = 1'b1;
            PC_WE       = 1'b1;
            w_nextState = ST_FETCH;
         end

         default: w_nextState = ST_INIT;
      endcase
   end

endmodule

// File: tb/tb_cu_fsm.sv
// Scoreboard bench for cu_fsm: two instances (interrupts enabled and disabled) share
// inputs; each cycle the expected output vectors are queued and checked at negedge.
module tb_cu_fsm;

   logic       CLK;
   logic       RST_N;
   logic       INTR;
   logic       MIE;
   logic [6:0] OPCODE;
   logic [2:0] FUNC3;
   logic       MEM_READY;

   logic       rstA, pcWeA, rfWeA, rd1A, rd2A, we2A, csrWeA, intA, mretA;
   logic [1:0] rfSelA;
   logic       rstB, pcWeB, rfWeB, rd1B, rd2B, we2B, csrWeB, intB, mretB;
   logic [1:0] rfSelB;

   cu_fsm #(.INTR_EN(1'b1)) dutA (
      .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .MIE(MIE), .OPCODE(OPCODE),
      .FUNC3(FUNC3), .MEM_READY(MEM_READY),
      .RST(rstA), .PC_WE(pcWeA), .RF_WE(rfWeA), .RF_SEL(rfSelA),
      .MEM_RDEN1(rd1A), .MEM_RDEN2(rd2A), .MEM_WE2(we2A), .CSR_WE(csrWeA),
      .INT_TAKEN(intA), .MRET_EXEC(mretA)
   );

   cu_fsm #(.INTR_EN(1'b0)) dutB (
      .CLK(CLK), .RST_N(RST_N), .INTR(INTR), .MIE(MIE), .OPCODE(OPCODE),
      .FUNC3(FUNC3), .MEM_READY(MEM_READY),
      .RST(rstB), .PC_WE(pcWeB), .RF_WE(rfWeB), .RF_SEL(rfSelB),
      .MEM_RDEN1(rd1B), .MEM_RDEN2(rd2B), .MEM_WE2(we2B), .CSR_WE(csrWeB),
      .INT_TAKEN(intB), .MRET_EXEC(mretB)
   );

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_ALUI   = 7'b0010011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_BOGUS  = 7'b1111111;

   typedef struct {
      logic [10:0] expA;
      logic [10:0] expB;
      string       name;
   } exp_t;

   exp_t expQ[$];
   int   checks   = 0;
   int   failures = 0;

   // Vector order: RST PC_WE RF_WE RF_SEL[1:0] RDEN1 RDEN2 WE2 CSR_WE INT_TAKEN MRET_EXEC
   function automatic logic [10:0] ev(input logic rst, pcWe, rfWe, input logic [1:0] sel,
                                      input logic rd1, rd2, we2, csrWe, intk, mret);
      return {rst, pcWe, rfWe, sel, rd1, rd2, we2, csrWe, intk, mret};
   endfunction

   logic [10:0] vInit, vFetch, vNop, vAlu, vJal, vCsr, vMret, vStore, vLoadEx,
                vWbWait, vWbDone, vIntr;

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   task automatic applyStimulus(input logic rstn, intr, mie, input logic [6:0] op,
                                input logic [2:0] f3, input logic rdy,
                                input logic [10:0] eA, eB, input string nm);
      exp_t e;
      @(posedge CLK);
      #1;
      RST_N     = rstn;
      INTR      = intr;
      MIE       = mie;
      OPCODE    = op;
      FUNC3     = f3;
      MEM_READY = rdy;
      e.expA = eA;
      e.expB = eB;
      e.name = nm;
      expQ.push_back(e);
   endtask

   task automatic checkOutput(input string nm, input logic [10:0] got, input logic [10:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("[TB] FAIL %s got=%b expected=%b", nm, got, exp);
      end
   endtask

   // Monitor: pops one expectation per cycle and compares both instances mid-cycle.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput({e.name, "/A"},
               {rstA, pcWeA, rfWeA, rfSelA, rd1A, rd2A, we2A, csrWeA, intA, mretA}, e.expA);
            checkOutput({e.name, "/B"},
               {rstB, pcWeB, rfWeB, rfSelB, rd1B, rd2B, we2B, csrWeB, intB, mretB}, e.expB);
         end
      end
   end

   initial begin
      vInit   = ev(1, 0, 0, 2'd3, 0, 0, 0, 0, 0, 0);
      vFetch  = ev(0, 0, 0, 2'd3, 1, 0, 0, 0, 0, 0);
      vNop    = ev(0, 1, 0, 2'd3, 0, 0, 0, 0, 0, 0);
      vAlu    = ev(0, 1, 1, 2'd3, 0, 0, 0, 0, 0, 0);
      vJal    = ev(0, 1, 1, 2'd0, 0, 0, 0, 0, 0, 0);
      vCsr    = ev(0, 1, 1, 2'd1, 0, 0, 0, 1, 0, 0);
      vMret   = ev(0, 1, 0, 2'd3, 0, 0, 0, 0, 0, 1);
      vStore  = ev(0, 1, 0, 2'd3, 0, 0, 1, 0, 0, 0);
      vLoadEx = ev(0, 0, 0, 2'd3, 0, 1, 0, 0, 0, 0);
      vWbWait = ev(0, 0, 0, 2'd2, 0, 1, 0, 0, 0, 0);
      vWbDone = ev(0, 1, 1, 2'd2, 0, 1, 0, 0, 0, 0);
      vIntr   = ev(0, 1, 0, 2'd3, 0, 0, 0, 0, 1, 0);

      RST_N = 1'b0; INTR = 1'b0; MIE = 1'b0; OPCODE = 7'd0; FUNC3 = 3'd0; MEM_READY = 1'b0;

      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 0, 7'd0, 3'd0, 0, vInit, vInit, "resetHeld");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vInit, vInit, "resetRelease");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "firstFetch");
      applyStimulus(1, 0, 0, OP_ALUI, 3'd0, 0, vAlu, vAlu, "addiExec");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "addiNextFetch");

      applyStimulus(1, 0, 0, OP_LOAD, 3'b010, 0, vLoadEx, vLoadEx, "lwExec");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vWbWait, vWbWait, "lwWait1");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vWbWait, vWbWait, "lwWait2");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 1, vWbDone, vWbDone, "lwCommit");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "lwNextFetch");

      applyStimulus(1, 1, 1, OP_JAL, 3'd0, 0, vJal, vJal, "jalIrqExec");
      applyStimulus(1, 1, 1, 7'd0, 3'd0, 0, vIntr, vFetch, "jalIrqTrap");
      applyStimulus(0, 0, 0, 7'd0, 3'd0, 0, vInit, vInit, "resync1");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vInit, vInit, "resync1Release");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "resync1Fetch");

      applyStimulus(1, 1, 1, OP_SYSTEM, 3'b001, 0, vCsr, vCsr, "csrrwExec");
      applyStimulus(1, 1, 1, 7'd0, 3'd0, 0, vIntr, vFetch, "csrrwTrap");
      applyStimulus(0, 0, 0, 7'd0, 3'd0, 0, vInit, vInit, "resync2");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vInit, vInit, "resync2Release");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "resync2Fetch");

      applyStimulus(1, 1, 0, OP_SYSTEM, 3'b000, 0, vMret, vMret, "mretIntrNoMie");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "mretNextFetch");
      applyStimulus(1, 0, 0, OP_STORE, 3'b010, 0, vStore, vStore, "storeExec");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "storeNextFetch");
      applyStimulus(1, 0, 0, OP_BRANCH, 3'd0, 0, vNop, vNop, "branchExec");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "branchNextFetch");
      applyStimulus(1, 0, 0, OP_SYSTEM, 3'b100, 0, vNop, vNop, "sysOtherExec");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "sysNextFetch");
      applyStimulus(1, 0, 0, OP_BOGUS, 3'd0, 0, vNop, vNop, "bogusOpNop");
      applyStimulus(1, 1, 1, 7'd0, 3'd0, 1, vFetch, vFetch, "fetchIgnoresIrq");
      applyStimulus(1, 0, 0, OP_LUI, 3'd0, 1, vAlu, vAlu, "luiExec");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 1, vFetch, vFetch, "fetchIgnoresReady");

      applyStimulus(1, 0, 0, OP_LOAD, 3'b010, 0, vLoadEx, vLoadEx, "lw2Exec");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vWbWait, vWbWait, "lw2Wait");
      applyStimulus(0, 0, 0, 7'd0, 3'd0, 0, vInit, vInit, "resetMidWb");
      applyStimulus(0, 0, 0, 7'd0, 3'd0, 1, vInit, vInit, "resetMidWbHeld");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 1, vInit, vInit, "resetMidWbRelease");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vFetch, "postResetFetch");

      applyStimulus(1, 0, 0, OP_LOAD, 3'b010, 0, vLoadEx, vLoadEx, "lw3Exec");
      applyStimulus(1, 1, 1, 7'd0, 3'd0, 1, vWbDone, vWbDone, "lw3CommitIrq");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vIntr, vFetch, "lw3Trap");
      applyStimulus(1, 0, 0, 7'd0, 3'd0, 0, vFetch, vNop, "lw3AfterTrap");

      repeat (3) @(posedge CLK);
      checks++;
      if (expQ.size() != 0) begin
         failures++;
         $display("[TB] FAIL queueDrain got=%0d expected=0", expQ.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
